// File: rtl/soc_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : soc_reset_sequencer
//  Description : Power-up / reset sequencer for the FPGA SoC top. It filters
//                the clock-wizard lock and pulses the DRAM controller reset.
//                It waits for DRAM calibration with a timeout, then holds the
//                SoC in reset and releases it, latching the boot mode. It also
//                handles software reset requests and loss of lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_reset_sequencer #(
   parameter int LOCK_FILTER_CYCLES   = 1024,
   parameter int RST_HOLD_CYCLES      = 64,
   parameter int CALIB_TIMEOUT_CYCLES = 2**24,
   parameter int USE_DDR              = 1,
   parameter int SYNC_STAGES          = 2
) (
   input  logic       soc_clk,
   input  logic       rst_n,
   input  logic       clk_locked_i,
   input  logic       ddr_calib_done_i,
   input  logic       sw_rst_req_i,
   input  logic [1:0] boot_mode_i,
   input  logic       test_mode_i,
   output logic       soc_rst_no,
   output logic       ddr_rst_o,
   output logic [1:0] boot_mode_o,
   output logic       calib_timeout_o,
   output logic [2:0] seq_state_o
);

   // One counter serves every timed state, so it is sized for the longest wait.
   localparam int c_max_ab  = (LOCK_FILTER_CYCLES > RST_HOLD_CYCLES) ?
                              LOCK_FILTER_CYCLES : RST_HOLD_CYCLES;
   localparam int c_cnt_max = (c_max_ab > CALIB_TIMEOUT_CYCLES) ?
                              c_max_ab : CALIB_TIMEOUT_CYCLES;
   localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

   localparam logic [c_cnt_w-1:0] c_lock_last  = c_cnt_w'(LOCK_FILTER_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(RST_HOLD_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_calib_last = c_cnt_w'(CALIB_TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_RESET      = 3'd0,
      S_WAIT_LOCK  = 3'd1,
      S_DDR_RST    = 3'd2,
      S_WAIT_CALIB = 3'd3,
      S_HOLD       = 3'd4,
      S_RUN        = 3'd5,
      S_ERROR      = 3'd6
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [c_cnt_w-1:0]     r_cnt;
   logic [c_cnt_w-1:0]     w_cnt_next;
   logic [SYNC_STAGES-1:0] r_lock_sync;
   logic [SYNC_STAGES-1:0] r_calib_sync;
   logic                   r_sw_rst_d;
   logic                   r_soc_rst_n;
   logic                   r_ddr_rst;
   logic [1:0]             r_boot_mode;
   logic [1:0]             w_boot_next;
   logic                   r_timeout;
   logic                   w_timeout_next;
   logic                   w_lk;
   logic                   w_cd;
   logic                   w_sr_rise;
   logic                   w_lock_lost;

   assign w_lk      = r_lock_sync[SYNC_STAGES-1];
   assign w_cd      = r_calib_sync[SYNC_STAGES-1];
   assign w_sr_rise = sw_rst_req_i & ~r_sw_rst_d;

   // Lock loss only matters once the sequence has left the lock filter.
   assign w_lock_lost = ~w_lk && (r_state != S_RESET) && (r_state != S_WAIT_LOCK);

   // Bring the asynchronous lock / calib-done inputs into soc_clk; remember last request level.
   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_sync  <= '0;
         r_calib_sync <= '0;
         r_sw_rst_d   <= 1'b0;
      end else begin
         r_lock_sync  <= {r_lock_sync[SYNC_STAGES-2:0], clk_locked_i};
         r_calib_sync <= {r_calib_sync[SYNC_STAGES-2:0], ddr_calib_done_i};
         r_sw_rst_d   <= sw_rst_req_i;
      end
   end

   // Next-state, counter, boot-mode latch and timeout flag decisions.
   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_boot_next    = r_boot_mode;
      w_timeout_next = r_timeout;
      case (r_state)
         S_RESET: begin
            w_state_next = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (!w_lk) begin
               w_cnt_next = '0;
            end else if (r_cnt == c_lock_last) begin
               w_state_next = (USE_DDR != 0) ? S_DDR_RST : S_HOLD;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         S_DDR_RST: begin
            if (r_cnt == c_hold_last) begin
               w_state_next = S_WAIT_CALIB;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         S_WAIT_CALIB: begin
            // Calibration done wins over a simultaneous timeout.
            if (w_cd) begin
               w_state_next = S_HOLD;
            end else if (r_cnt == c_calib_last) begin
               w_state_next   = S_ERROR;
               w_timeout_next = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         S_HOLD: begin
            // A held software request freezes the count and so extends HOLD.
            if (!sw_rst_req_i) begin
               if (r_cnt == c_hold_last) begin
                  w_state_next = S_RUN;
                  w_boot_next  = boot_mode_i;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         S_RUN: begin
            if (w_sr_rise) begin
               w_state_next = S_HOLD;
            end
         end
         S_ERROR: begin
            if (w_sr_rise) begin
               w_state_next   = S_DDR_RST;
               w_timeout_next = 1'b0;
            end
         end
         default: begin
            w_state_next = S_RESET;
         end
      endcase
      // Lock loss overrides every other decision, including flag and latch updates.
      if (w_lock_lost) begin
         w_state_next   = S_WAIT_LOCK;
         w_boot_next    = r_boot_mode;
         w_timeout_next = r_timeout;
      end
      if (w_state_next != r_state) begin
         w_cnt_next = '0;
      end
   end

   // State, counter and registered outputs; outputs follow the state being entered.
   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_RESET;
         r_cnt       <= '0;
         r_soc_rst_n <= 1'b0;
         r_ddr_rst   <= 1'b1;
         r_boot_mode <= 2'b00;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_soc_rst_n <= (w_state_next == S_RUN);
         r_ddr_rst   <= (w_state_next == S_RESET) || (w_state_next == S_WAIT_LOCK) ||
                        (w_state_next == S_DDR_RST);
         r_boot_mode <= w_boot_next;
         r_timeout   <= w_timeout_next;
      end
   end

   // DFT bypass hands the SoC reset straight to the board reset.
   assign soc_rst_no      = test_mode_i ? rst_n : r_soc_rst_n;
   assign ddr_rst_o       = r_ddr_rst;
   assign boot_mode_o     = r_boot_mode;
   assign calib_timeout_o = r_timeout;
   assign seq_state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_soc_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_reset_sequencer
//  Description : Directed scoreboard bench for soc_reset_sequencer. Stimulus
//                queues the expected state transitions (outputs on entry and
//                cycles spent in the previous state); a negedge monitor pops
//                and compares on every observed state change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_reset_sequencer;

   logic       soc_clk          = 1'b0;
   logic       rst_n            = 1'b0;
   logic       clk_locked_i     = 1'b1;
   logic       ddr_calib_done_i = 1'b0;
   logic       sw_rst_req_i     = 1'b0;
   logic [1:0] boot_mode_i      = 2'b10;
   logic       test_mode_i      = 1'b0;
   wire        soc_rst_no;
   wire        ddr_rst_o;
   wire  [1:0] boot_mode_o;
   wire        calib_timeout_o;
   wire  [2:0] seq_state_o;

   soc_reset_sequencer #(
      .LOCK_FILTER_CYCLES   (8),
      .RST_HOLD_CYCLES      (4),
      .CALIB_TIMEOUT_CYCLES (100),
      .USE_DDR              (1),
      .SYNC_STAGES          (2)
   ) dut (
      .soc_clk          (soc_clk),
      .rst_n            (rst_n),
      .clk_locked_i     (clk_locked_i),
      .ddr_calib_done_i (ddr_calib_done_i),
      .sw_rst_req_i     (sw_rst_req_i),
      .boot_mode_i      (boot_mode_i),
      .test_mode_i      (test_mode_i),
      .soc_rst_no       (soc_rst_no),
      .ddr_rst_o        (ddr_rst_o),
      .boot_mode_o      (boot_mode_o),
      .calib_timeout_o  (calib_timeout_o),
      .seq_state_o      (seq_state_o)
   );

   always #5 soc_clk = ~soc_clk;

   typedef struct {
      int state;
      int soc_rst_n;
      int ddr_rst;
      int boot;
      int timeout;
      int dwell;   // cycles spent in the previous state, -1 = not checked
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         checks   = 0;
   int         errors   = 0;
   int         cyc      = 0;
   int         last_chg = 0;
   int         trans_no = 0;
   logic [2:0] mon_prev = 3'd7;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int st, input int srn, input int dr, input int bm,
                       input int to, input int dw);
      exp_t e;
      e.state     = st;
      e.soc_rst_n = srn;
      e.ddr_rst   = dr;
      e.boot      = bm;
      e.timeout   = to;
      e.dwell     = dw;
      exp_q.push_back(e);
   endtask

   task automatic wait_state(input int s, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge soc_clk);
         n++;
      end while ((int'(seq_state_o) != s) && (n < budget));
      if (int'(seq_state_o) != s) begin
         checks++;
         errors++;
         $display("FAIL wait_state: got state %0d, expected %0d within %0d cycles",
                  seq_state_o, s, budget);
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   endtask

   // Monitor: every change of the state output is one scoreboard transaction.
   always @(negedge soc_clk) begin
      cyc++;
      if (seq_state_o != mon_prev) begin
         trans_no++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL trans%0d_unexpected: got state %0d, expected no transition",
                     trans_no, seq_state_o);
         end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("trans%0d_state", trans_no), int'(seq_state_o), mon_e.state);
            check($sformatf("trans%0d_soc_rst_no", trans_no), int'(soc_rst_no), mon_e.soc_rst_n);
            check($sformatf("trans%0d_ddr_rst_o", trans_no), int'(ddr_rst_o), mon_e.ddr_rst);
            check($sformatf("trans%0d_boot_mode_o", trans_no), int'(boot_mode_o), mon_e.boot);
            check($sformatf("trans%0d_calib_timeout_o", trans_no), int'(calib_timeout_o),
                  mon_e.timeout);
            if (mon_e.dwell >= 0)
               check($sformatf("trans%0d_prev_dwell", trans_no), cyc - last_chg, mon_e.dwell);
         end
         mon_prev = seq_state_o;
         last_chg = cyc;
      end
   end

   initial begin
      // Nominal boot: lock high from t0, calib done 20 cycles after ddr reset falls.
      push(0, 0, 1, 2'b00, 0, -1);
      push(1, 0, 1, 2'b00, 0, -1);
      push(2, 0, 1, 2'b00, 0, 9);
      push(3, 0, 0, 2'b00, 0, 4);
      push(4, 0, 0, 2'b00, 0, 23);
      push(5, 1, 0, 2'b10, 0, 4);
      repeat (3) @(negedge soc_clk);
      rst_n = 1'b1;
      wait_state(3, 100);
      repeat (20) @(negedge soc_clk);
      ddr_calib_done_i = 1'b1;
      wait_state(5, 100);

      // Software reset held 10 cycles with a new boot mode.
      push(4, 0, 0, 2'b10, 0, 1);
      push(5, 1, 0, 2'b01, 0, 13);
      boot_mode_i  = 2'b01;
      sw_rst_req_i = 1'b1;
      repeat (10) @(negedge soc_clk);
      sw_rst_req_i = 1'b0;
      wait_state(5, 100);

      // Calib-done drop in RUN (ignored), then lock loss and a glitchy relock.
      push(1, 0, 1, 2'b01, 0, 9);
      push(2, 0, 1, 2'b01, 0, 16);
      push(3, 0, 0, 2'b01, 0, 4);
      push(4, 0, 0, 2'b01, 0, 8);
      push(5, 1, 0, 2'b11, 0, 4);
      ddr_calib_done_i = 1'b0;
      repeat (6) @(negedge soc_clk);
      clk_locked_i = 1'b0;
      boot_mode_i  = 2'b11;
      wait_state(1, 20);
      clk_locked_i = 1'b1;
      repeat (5) @(negedge soc_clk);
      clk_locked_i = 1'b0;
      @(negedge soc_clk);
      clk_locked_i = 1'b1;
      wait_state(3, 100);
      repeat (5) @(negedge soc_clk);
      ddr_calib_done_i = 1'b1;
      wait_state(5, 100);

      // Calibration timeout, software recovery, second timeout, sticky flag over lock loss.
      push(1, 0, 1, 2'b11, 0, 3);
      push(2, 0, 1, 2'b11, 0, 10);
      push(3, 0, 0, 2'b11, 0, 4);
      push(6, 0, 0, 2'b11, 1, 100);
      push(2, 0, 1, 2'b11, 0, 1);
      push(3, 0, 0, 2'b11, 0, 4);
      push(6, 0, 0, 2'b11, 1, 100);
      push(1, 0, 1, 2'b11, 1, 3);
      push(2, 0, 1, 2'b11, 1, 10);
      push(3, 0, 0, 2'b11, 1, 4);
      ddr_calib_done_i = 1'b0;
      clk_locked_i     = 1'b0;
      wait_state(1, 20);
      clk_locked_i = 1'b1;
      wait_state(6, 200);
      sw_rst_req_i = 1'b1;
      @(negedge soc_clk);
      sw_rst_req_i = 1'b0;
      wait_state(6, 200);
      clk_locked_i = 1'b0;
      wait_state(1, 20);
      clk_locked_i = 1'b1;
      wait_state(3, 50);

      // Test-mode bypass and asynchronous reset in the middle of WAIT_CALIB.
      push(0, 0, 1, 2'b00, 0, -1);
      push(1, 0, 1, 2'b00, 0, -1);
      push(2, 0, 1, 2'b00, 0, 9);
      #2;
      check("timeout_before_async_reset", int'(calib_timeout_o), 1);
      test_mode_i = 1'b1;
      #1;
      check("test_mode_soc_rst_no_high", int'(soc_rst_no), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("test_mode_soc_rst_no_low", int'(soc_rst_no), 0);
      check("async_reset_state", int'(seq_state_o), 0);
      check("async_reset_ddr_rst_o", int'(ddr_rst_o), 1);
      check("async_reset_boot_mode_o", int'(boot_mode_o), 0);
      check("async_reset_calib_timeout_o", int'(calib_timeout_o), 0);
      test_mode_i = 1'b0;
      repeat (3) @(negedge soc_clk);
      rst_n = 1'b1;
      wait_state(2, 50);
      @(negedge soc_clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      checks++;
      errors++;
      $display("FAIL watchdog: got time limit reached, expected sequence end");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/soc_reset_sequencer.md
Name:
soc_reset_sequencer

Overview:
Power-up and reset sequencer for the FPGA SoC top. It waits for a filtered clock-wizard lock, then pulses the DRAM controller reset and waits for DRAM calibration, with a timeout. It then holds the SoC in reset for a fixed time and releases it, latching the boot mode at the moment of release. It also handles software (VIO) reset requests and loss of clock lock while running.

Parameters:
LockFilterCycles, 1024, consecutive cycles of synchronized lock high required before proceeding (>=1)
RstHoldCycles, 64, cycles ddr_rst_o / SoC reset are held in DDR_RST and HOLD (>=1)
CalibTimeoutCycles, 2**24, cycles allowed in WAIT_CALIB before timeout (>=1)
UseDdr, 1, 0 = skip DDR_RST/WAIT_CALIB (WAIT_LOCK goes directly to HOLD)
SyncStages, 2, flip-flop stages on clk_locked_i and ddr_calib_done_i (>=2)

Ports:
soc_clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset, clock soc_clk
clk_locked_i  in  1  clock wizard locked, asynchronous, synchronized internally
ddr_calib_done_i  in  1  DRAM calibration complete, asynchronous, synchronized internally
sw_rst_req_i  in  1  software/VIO reset request, level, soc_clk domain
boot_mode_i  in  2  boot mode selection (switch/VIO mux output)
test_mode_i  in  1  DFT bypass
soc_rst_no  out  1  SoC reset, active low
ddr_rst_o  out  1  DRAM controller reset, active high
boot_mode_o  out  2  boot mode latched at SoC reset release
calib_timeout_o  out  1  sticky calibration-timeout flag
seq_state_o  out  3  current FSM state encoding

Behaviour:
- Single shared counter, width $clog2(max(LockFilterCycles,RstHoldCycles,CalibTimeoutCycles)+1); counter cleared on every state change.
- Reset values: state=RESET, soc_rst_no=0, ddr_rst_o=1, boot_mode_o=2'b00, calib_timeout_o=0, counter=0.
- All outputs registered, except the test_mode_i bypass described below.
- lk and cd denote the synchronized lock and calib-done signals. sr_rise = sw_rst_req_i high this cycle and low the previous cycle; the edge register resets to 0.
- State encodings: RESET=0, WAIT_LOCK=1, DDR_RST=2, WAIT_CALIB=3, HOLD=4, RUN=5, ERROR=6.
- RESET: soc_rst_no=0, ddr_rst_o=1. Goes to WAIT_LOCK unconditionally the next cycle.
- WAIT_LOCK: soc_rst_no=0, ddr_rst_o=1. Counter increments while lk=1 and clears while lk=0. When lk=1 and counter==LockFilterCycles-1, go to DDR_RST (UseDdr=1) or HOLD (UseDdr=0).
- DDR_RST: ddr_rst_o=1, soc_rst_no=0. After RstHoldCycles cycles in the state, go to WAIT_CALIB.
- WAIT_CALIB: ddr_rst_o=0, soc_rst_no=0.
  - cd=1: go to HOLD.
  - Else, counter==CalibTimeoutCycles-1: set calib_timeout_o=1 and go to ERROR.
  - If both occur in the same cycle, cd wins.
- HOLD: soc_rst_no=0, ddr_rst_o=0. Counter increments only while sw_rst_req_i=0 (a held request extends HOLD). At counter==RstHoldCycles-1, go to RUN and latch boot_mode_o<=boot_mode_i in the same cycle.
- RUN: soc_rst_no=1, ddr_rst_o=0. boot_mode_o is stable; boot_mode_i changes are ignored.
  - sr_rise: go to HOLD, so soc_rst_no=0 from the next cycle. The DRAM is not reset.
  - cd falling to 0 in RUN: no action.
- ERROR: soc_rst_no=0, ddr_rst_o=0. sr_rise: clear calib_timeout_o and go to DDR_RST.
- Lock loss: lk=0 in DDR_RST, WAIT_CALIB, HOLD, RUN or ERROR goes to WAIT_LOCK. It has priority over every other transition. soc_rst_no=0 and ddr_rst_o=1 are registered on the following edge.
- calib_timeout_o: sticky across lock loss; cleared only by rst_n or the ERROR exit.
- test_mode_i=1: soc_rst_no = rst_n combinationally; the FSM keeps running unchanged.
- Asynchronous rst_n at any time returns every register to its reset value within the same cycle.
- seq_state_o is the registered state encoding.

Test Plan:
Bench parameters: LockFilterCycles=8, RstHoldCycles=4, CalibTimeoutCycles=100, SyncStages=2, UseDdr=1.
- Nominal boot: clk_locked_i=1 from t0, ddr_calib_done_i rises 20 cycles after ddr_rst_o falls, boot_mode_i=2'b10 -> ddr_rst_o high for exactly 4 cycles in DDR_RST; soc_rst_no rises 4 cycles after HOLD entry; boot_mode_o=2'b10; calib_timeout_o=0.
- Lock glitch: lock high 5 cycles, low 1, then high -> filter restarts; DDR_RST entered only after 8 consecutive synchronized-high cycles.
- Calibration timeout: ddr_calib_done_i held 0 -> calib_timeout_o=1 after 100 cycles in WAIT_CALIB, state 6, soc_rst_no=0. Then one sw_rst_req_i pulse -> flag cleared, state 2.
- Software reset: in RUN, sw_rst_req_i held high 10 cycles with boot_mode_i changed to 2'b01 -> soc_rst_no low the cycle after the rising edge, ddr_rst_o stays 0; release occurs 4 cycles after the request drops; boot_mode_o=2'b01.
- Lock loss in RUN: clk_locked_i deasserted -> within SyncStages+1 cycles soc_rst_no=0, ddr_rst_o=1, state 1; full sequence repeats on relock.
- Test mode and async reset: test_mode_i=1 -> soc_rst_no tracks rst_n combinationally. rst_n pulsed low mid-WAIT_CALIB -> all outputs at reset values immediately, calib_timeout_o=0.
